// File: rtl/i2c_cmd_queue_if.sv
// Command-queue bundle: host write port, status, and I2C_master issue port.
// The slave modport is the queue; the master modport is its environment.
interface i2c_cmd_queue_if #(
  parameter int AW = 3
);
  logic          wr_en;
  logic [6:0]    wr_addr;
  logic [7:0]    wr_sub;
  logic [7:0]    wr_data;
  logic          full;
  logic          empty;
  logic [AW:0]   count;
  logic          overflow;
  logic          master_ready;
  logic          master_start;
  logic [6:0]    master_addr;
  logic [7:0]    master_sub;
  logic [7:0]    master_data;
  logic          busy;
  logic          done;
  logic          timeout_err;

  modport slave (
    input  wr_en,
    input  wr_addr,
    input  wr_sub,
    input  wr_data,
    input  master_ready,
    output full,
    output empty,
    output count,
    output overflow,
    output master_start,
    output master_addr,
    output master_sub,
    output master_data,
    output busy,
    output done,
    output timeout_err
  );

  modport master (
    output wr_en,
    output wr_addr,
    output wr_sub,
    output wr_data,
    output master_ready,
    input  full,
    input  empty,
    input  count,
    input  overflow,
    input  master_start,
    input  master_addr,
    input  master_sub,
    input  master_data,
    input  busy,
    input  done,
    input  timeout_err
  );
endinterface

// File: rtl/i2c_cmd_queue.sv
// Register-write command FIFO and one-at-a-time issue sequencer
// feeding I2C_master through its start/ready handshake.
module i2c_cmd_queue #(
  parameter int DEPTH       = 8,
  parameter int AW          = 3,
  parameter int ACK_TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  i2c_cmd_queue_if.slave q
);

  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE
  } state_t;

  typedef struct packed {
    logic [6:0] addr;
    logic [7:0] sub;
    logic [7:0] data;
  } cmd_t;

  cmd_t          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          full_r;
  logic          empty_r;
  logic          ovf_r;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] tmr;
  logic [TW-1:0] tmr_nxt;
  cmd_t          cur;
  logic          done_r;
  logic          done_nxt;
  logic          tmo_r;
  logic          tmo_nxt;

  logic          pop;
  logic          push;
  logic          drop;
  cmd_t          wr_cmd;

  assign wr_cmd = '{
    addr: q.wr_addr,
    sub:  q.wr_sub,
    data: q.wr_data
  };

  // A pop frees a slot on the same edge, so a full queue still accepts.
  assign push = q.wr_en & (~full_r | pop);
  assign drop = q.wr_en & full_r & ~pop;

  always_comb begin
    state_nxt = state;
    tmr_nxt   = tmr;
    done_nxt  = 1'b0;
    tmo_nxt   = 1'b0;
    pop       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!empty_r && q.master_ready) begin
          pop       = 1'b1;
          tmr_nxt   = '0;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (!q.master_ready) begin
          state_nxt = WAIT_DONE;
        end else if (tmr == TW'(ACK_TIMEOUT - 1)) begin
          tmo_nxt   = 1'b1;
          state_nxt = IDLE;
        end else begin
          tmr_nxt = tmr + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (q.master_ready) begin
          done_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      tmr    <= '0;
      cur    <= '0;
      done_r <= 1'b0;
      tmo_r  <= 1'b0;
    end else begin
      state  <= state_nxt;
      tmr    <= tmr_nxt;
      done_r <= done_nxt;
      tmo_r  <= tmo_nxt;
      if (pop) begin
        cur <= mem[rd_ptr];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full_r  <= 1'b0;
      empty_r <= 1'b1;
      ovf_r   <= 1'b0;
    end else begin
      ovf_r <= drop;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10: begin
          cnt     <= cnt + 1'b1;
          full_r  <= (cnt == (AW+1)'(DEPTH - 1));
          empty_r <= 1'b0;
        end
        2'b01: begin
          cnt     <= cnt - 1'b1;
          full_r  <= 1'b0;
          empty_r <= (cnt == (AW+1)'(1));
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  // Storage needs no reset: the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= wr_cmd;
    end
  end

  assign q.full         = full_r;
  assign q.empty        = empty_r;
  assign q.count        = cnt;
  assign q.overflow     = ovf_r;
  assign q.master_start = (state == ISSUE);
  assign q.busy         = (state != IDLE);
  assign q.master_addr  = cur.addr;
  assign q.master_sub   = cur.sub;
  assign q.master_data  = cur.data;
  assign q.done         = done_r;
  assign q.timeout_err  = tmo_r;

endmodule

// File: tb/tb_i2c_cmd_queue.sv
// Randomized scoreboard bench for i2c_cmd_queue against a
// transaction-level queue model and a reactive I2C_master responder.
module tb_i2c_cmd_queue;

  localparam int DEPTH  = 8;
  localparam int AW     = 3;
  localparam int ACK_TO = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;

  i2c_cmd_queue_if #(.AW(AW)) q ();

  i2c_cmd_queue #(
    .DEPTH(DEPTH),
    .AW(AW),
    .ACK_TIMEOUT(ACK_TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .q(q)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the queue as a list of commands plus the phase of
  // the command in flight (0 none, 1 start asserted, 2 awaiting ready).
  logic [22:0] m_q[$];
  logic [22:0] sb[$];
  int          m_ph = 0;
  int          m_k = 0;
  bit          m_done = 0;
  bit          m_tmo = 0;
  bit          m_ovf = 0;

  always @(posedge clk or posedge reset) begin
    bit pop;
    bit was_full;
    if (reset) begin
      m_q.delete();
      sb.delete();
      m_ph   = 0;
      m_k    = 0;
      m_done = 0;
      m_tmo  = 0;
      m_ovf  = 0;
    end else begin
      m_done   = 0;
      m_tmo    = 0;
      m_ovf    = 0;
      was_full = (m_q.size() == DEPTH);
      pop      = (m_ph == 0) && (m_q.size() != 0) && q.master_ready;
      if (m_ph == 1) begin
        if (!q.master_ready) begin
          m_ph = 2;
        end else begin
          m_k++;
          if (m_k == ACK_TO) begin
            m_ph  = 0;
            m_tmo = 1;
          end
        end
      end else if (m_ph == 2 && q.master_ready) begin
        m_ph   = 0;
        m_done = 1;
      end
      if (pop) begin
        sb.push_back(m_q.pop_front());
        m_ph = 1;
        m_k  = 0;
      end
      if (q.wr_en) begin
        if (!was_full || pop)
          m_q.push_back({q.wr_addr, q.wr_sub, q.wr_data});
        else
          m_ovf = 1;
      end
    end
  end

  // Monitor: per-cycle status against the model, issues against the
  // scoreboard, and timeout latency measured from the start edge.
  int  cyc = 0;
  int  start_cyc = 0;
  bit  prev_start = 0;

  always @(negedge clk) begin
    logic [10:0] exp_st;
    logic [22:0] e;
    cyc++;
    exp_st = {4'(m_q.size()), m_q.size() == DEPTH, m_q.size() == 0,
              m_ovf, m_ph != 0, m_ph == 1, m_done, m_tmo};
    chk("status", {q.count, q.full, q.empty, q.overflow, q.busy,
                   q.master_start, q.done, q.timeout_err}, exp_st);
    if (q.master_start && !prev_start) begin
      start_cyc = cyc;
      if (sb.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL issue: start with no expected command at %0t", $time);
      end else begin
        e = sb.pop_front();
        chk("issue", {q.master_addr, q.master_sub, q.master_data}, e);
      end
    end
    if (q.timeout_err)
      chk("tmo_lat", cyc - start_cyc, ACK_TO);
    prev_start = q.master_start;
  end

  // Responder standing in for I2C_master. mode 0: ready held low;
  // mode 1: acknowledges each start; mode 2: never leaves ready.
  int mode = 1;
  int drop_cfg = -1;
  int low_cfg = -1;

  initial begin
    int st;
    int w;
    st = 0;
    w  = 0;
    q.master_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      if (reset) begin
        st = 0;
        q.master_ready = (mode != 0);
      end else begin
        case (st)
          0: begin
            q.master_ready = (mode != 0);
            if (mode == 1 && q.master_start) begin
              w  = (drop_cfg >= 0) ? drop_cfg : $urandom_range(0, 4);
              st = 1;
            end
          end
          1: begin
            if (w == 0) begin
              q.master_ready = 1'b0;
              w  = (low_cfg >= 0) ? low_cfg : $urandom_range(1, 10);
              st = 2;
            end else begin
              w--;
            end
          end
          default: begin
            if (w == 0) begin
              q.master_ready = 1'b1;
              st = 0;
            end else begin
              w--;
            end
          end
        endcase
      end
    end
  end

  task automatic push_cmd(input logic [6:0] a, input logic [7:0] s,
                          input logic [7:0] d);
    q.wr_en   = 1'b1;
    q.wr_addr = a;
    q.wr_sub  = s;
    q.wr_data = d;
    @(posedge clk);
    #1;
    q.wr_en = 1'b0;
  endtask

  task automatic push_rand();
    push_cmd(7'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((m_q.size() != 0 || m_ph != 0) && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_idle: queue not drained after %0d cycles", n);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("rst_start", q.master_start, 1'b0);
    chk("rst_busy", q.busy, 1'b0);
    chk("rst_count", q.count, 0);
    chk("rst_empty", q.empty, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    int n;
    q.wr_en   = 1'b0;
    q.wr_addr = '0;
    q.wr_sub  = '0;
    q.wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_bus", {q.master_addr, q.master_sub, q.master_data}, 0);
    chk("rst_flags", {q.empty, q.full, q.busy}, 3'b100);

    // Single command, slow acknowledge.
    drop_cfg = 3;
    low_cfg  = 40;
    push_cmd(7'h55, 8'hAA, 8'hAA);
    wait_idle();
    drop_cfg = -1;
    low_cfg  = -1;

    // Fill while the master is stalled, then overflow.
    mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++)
      push_cmd(7'(i + 1), 8'(8'h10 + i), 8'(8'hE0 + i));
    push_cmd(7'h7F, 8'hFF, 8'hFF);
    repeat (2) @(posedge clk);
    #1;
    mode = 1;
    wait_idle();

    // Push lands on the same edge as a pop from a full queue.
    mode = 0;
    @(posedge clk);
    #1;
    for (int i = 0; i < DEPTH; i++)
      push_rand();
    mode = 1;
    push_cmd(7'h3C, 8'h5A, 8'hC3);
    wait_idle();

    // Master never acknowledges: each command times out.
    mode = 2;
    push_rand();
    push_rand();
    wait_idle();
    mode = 1;

    // Reset while a command waits on the master, with entries queued.
    drop_cfg = 0;
    low_cfg  = 30;
    for (int i = 0; i < 4; i++)
      push_rand();
    n = 0;
    while (m_ph != 2 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("reach_wait", (n < 100), 1'b1);
    do_reset();
    drop_cfg = -1;
    low_cfg  = -1;
    repeat (5) @(posedge clk);
    #1;

    // Two consecutive pushes into an empty stalled queue.
    mode = 0;
    @(posedge clk);
    #1;
    push_rand();
    push_rand();
    mode = 1;
    wait_idle();

    // Random traffic with stalls.
    for (int i = 0; i < 400; i++) begin
      if (i % 40 == 0)
        mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      q.wr_en   = ($urandom_range(0, 2) == 0);
      q.wr_addr = 7'($urandom);
      q.wr_sub  = 8'($urandom);
      q.wr_data = 8'($urandom);
      @(posedge clk);
      #1;
    end
    q.wr_en = 1'b0;
    mode = 1;
    wait_idle();
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
